// File: rtl/pipeline_fifo.sv
// Pipeline FIFO: a full FIFO accepts an enqueue in the cycle it is dequeued.
// Port ordering within a cycle is deq, then enq, then clear.
module pipeline_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enq_valid,
    input  logic [N-1:0]                 enq_data,
    output logic                         enq_ready,
    output logic                         deq_valid,
    output logic [N-1:0]                 deq_data,
    input  logic                         deq_ready,
    input  logic                         clear,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Handshake: a transfer fires on a rising edge where valid && ready are both
    // high; valid never waits on ready, and only enq_ready looks at deq_ready.
    logic [N-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_hd;
    logic [PW-1:0] r_tl;
    logic [CW-1:0] r_cnt;

    logic w_full;
    logic w_empty;
    logic w_enq_fire;
    logic w_deq_fire;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full     = (r_cnt == CW'(DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign deq_valid  = !w_empty;
    assign deq_data   = r_mem[r_hd];
    assign count      = r_cnt;
    assign enq_ready  = !w_full || deq_ready;
    assign w_deq_fire = deq_valid && deq_ready;
    assign w_enq_fire = enq_valid && enq_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hd  <= '0;
            r_tl  <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_hd  <= '0;
            r_tl  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_deq_fire) r_hd <= ptr_next(r_hd);
            if (w_enq_fire) r_tl <= ptr_next(r_tl);
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Clear discards a same-cycle enqueue, so storage is not written then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (!clear && w_enq_fire) begin
            r_mem[r_tl] <= enq_data;
        end
    end
endmodule
